// File: rtl/aap_prefetch.sv
// aap_prefetch: streams 16-bit words from synchronous instruction memory into a
// DEPTH-word circular buffer and hands 16/32-bit AAP instructions to decode.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_ren, i_raddr, i_rdata  instruction memory (data one cycle after i_ren)
//   redirect, redirect_pc    flush buffer and restart fetch at a word address
//   instr_valid/ready        decode handshake
//   instr, instr_pc, len     assembled instruction, word address of w0, 32-bit flag
//   perf_stall               decode-starve counter
//
// Build option: define AAP_FETCH_PERF_EN to implement perf_stall; otherwise
// it is tied to zero and no counter exists.

module aap_prefetch #(
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              i_ren,
  output logic [ADDR_W-1:0] i_raddr,
  input  logic [15:0]       i_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_len,
  output logic [31:0]       perf_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [ADDR_W-1:0] hpc_q, hpc_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              inf_q, inf_d;
  logic [15:0]       buf_q [DEPTH];
  logic [15:0]       buf_d [DEPTH];

  logic [15:0] w0, w1;
  logic        is32;
  logic        hs;
  logic        push;
  logic [1:0]  pop_n;
  logic [CW:0] occ, lim;

  // Head of the buffer and instruction assembly.
  always_comb begin
    w0          = buf_q[rd_q];
    w1          = buf_q[rd_q + PW'(1)];
    is32        = w0[15];
    instr_valid = ((cnt_q != '0) & ~is32) | (cnt_q >= CW'(2));
    instr_len   = instr_valid & is32;
    instr       = '0;
    if (instr_valid) begin
      instr = is32 ? {w0, w1} : {w0, 16'h0000};
    end
    instr_pc    = hpc_q;
  end

  // Handshake in a redirect cycle is not a consume.
  always_comb begin
    hs    = instr_valid & instr_ready & ~redirect;
    pop_n = 2'd0;
    if (hs) begin
      pop_n = is32 ? 2'd2 : 2'd1;
    end
  end

  // Issue credit: occupied slots (stored + in flight) minus this cycle's pop
  // must leave room for one more word.
  always_comb begin
    occ     = {1'b0, cnt_q} + (CW+1)'(inf_q);
    lim     = (CW+1)'(DEPTH) + (CW+1)'(pop_n);
    i_ren   = ~rst & ~redirect & (occ < lim);
    i_raddr = fa_q;
  end

  // A response always lands in the cycle after its issue. If that cycle is a
  // redirect, the redirect branch below simply never writes it, so the stale
  // word is discarded without needing a separate drop flag.
  assign push = inf_q;

  always_comb begin
    fa_d  = fa_q;
    hpc_d = hpc_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    inf_d = inf_q;
    buf_d = buf_q;
    if (redirect) begin
      fa_d  = redirect_pc;
      hpc_d = redirect_pc;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      inf_d = 1'b0;
    end else begin
      inf_d = i_ren;
      if (i_ren) begin
        fa_d = fa_q + ADDR_W'(1);
      end
      if (push) begin
        buf_d[wr_q] = i_rdata;
        wr_d        = wr_q + PW'(1);
      end
      rd_d  = rd_q + PW'(pop_n);
      hpc_d = hpc_q + ADDR_W'(pop_n);
      cnt_d = cnt_q + CW'(push) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q  <= '0;
      hpc_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      inf_q <= 1'b0;
    end else begin
      fa_q  <= fa_d;
      hpc_q <= hpc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      inf_q <= inf_d;
    end
  end

  // Buffer storage is data only; outputs are masked while count is zero.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef AAP_FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (instr_ready & ~instr_valid & (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule
